// File: rtl/regblock_pkg.sv
// Shared definitions for the register-block pipeline.
//   alu_op_e     : ALU operation codes carried on ALUopsel
//   DEF_*        : default widths for the 32-bit processor build
package regblock_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_RWIDTH = 6;
  localparam int DEF_IWIDTH = 15;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_AND   = 4'b0001,
    ALU_OR    = 4'b0010,
    ALU_SUB   = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSA = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/regblock_rf.sv
// 2-read / 2-write register file.
//   clk, rst_n        : clock, async active-low reset (clears every entry)
//   ra_a/ra_b -> rd_a/rd_b : write-through read ports
//   wb_en/wb_addr/wb_data  : ALU write-back port (higher priority)
//   we/wa/wd               : external write port
// ZERO_REG=1 pins entry 0 to zero and overrides any bypass to it.
module regblock_rf
  import regblock_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int RWIDTH   = DEF_RWIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RWIDTH-1:0] ra_a,
  input  logic [RWIDTH-1:0] ra_b,
  output logic [DWIDTH-1:0] rd_a,
  output logic [DWIDTH-1:0] rd_b,
  input  logic              wb_en,
  input  logic [RWIDTH-1:0] wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              we,
  input  logic [RWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd
);

  localparam int NREG = 2**RWIDTH;

  logic [NREG-1:0][DWIDTH-1:0] regs;

  // Write-back beats the external port when both hit the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ZERO_REG != 0 && i == 0)
          regs[i] <= '0;
        else if (wb_en && wb_addr == RWIDTH'(i))
          regs[i] <= wb_data;
        else if (we && wa == RWIDTH'(i))
          regs[i] <= wd;
      end
    end
  end

  // Same-cycle writes are forwarded so a dependent op needs no stall;
  // bypass order mirrors the write priority, zero register checked last.
  function automatic logic [DWIDTH-1:0] rd_port(input logic [RWIDTH-1:0] a);
    logic [DWIDTH-1:0] d;
    d = regs[a];
    if (we && wa == a)         d = wd;
    if (wb_en && wb_addr == a) d = wb_data;
    if (ZERO_REG != 0 && a == '0) d = '0;
    return d;
  endfunction

  always_comb begin
    rd_a = rd_port(ra_a);
    rd_b = rd_port(ra_b);
  end

endmodule

// File: rtl/regblock_pipe.sv
// Register file + operand-B select + ALU + one registered result stage.
//   in_valid/in_ready   : operation handshake (in_ready = !out_valid || out_ready)
//   rs, rt, rd          : operand A, operand B / store-data, destination regs
//   imm_in, imm_sext    : immediate and its extension mode
//   muxsel1             : 1 = operand B from immediate
//   wb_en               : write result to rd when it retires
//   ALUopsel            : alu_op_e code
//   we, wa, wd          : external register write
//   out_valid/out_ready : result handshake
//   ALUresult, opBwd, out_rd, zero, ovf : registered result fields
// IWIDTH must be less than DWIDTH.
module regblock_pipe
  import regblock_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int RWIDTH   = DEF_RWIDTH,
  parameter int IWIDTH   = DEF_IWIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RWIDTH-1:0] rs,
  input  logic [RWIDTH-1:0] rt,
  input  logic [RWIDTH-1:0] rd,
  input  logic [IWIDTH-1:0] imm_in,
  input  logic              imm_sext,
  input  logic              muxsel1,
  input  logic              wb_en,
  input  logic [3:0]        ALUopsel,
  input  logic              we,
  input  logic [RWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] ALUresult,
  output logic [DWIDTH-1:0] opBwd,
  output logic [RWIDTH-1:0] out_rd,
  output logic              zero,
  output logic              ovf
);

  localparam int SHW = $clog2(DWIDTH);
  localparam int MSB = DWIDTH - 1;

  typedef struct packed {
    logic [DWIDTH-1:0] res;
    logic [DWIDTH-1:0] opb;
    logic [RWIDTH-1:0] rd;
    logic              zero;
    logic              ovf;
    logic              wb;
  } resp_t;

  resp_t             out_q, nxt;
  logic              acc, wb_fire;
  logic [DWIDTH-1:0] op_a, rt_val, op_b, imm_ext, alu_res;
  logic              alu_ovf;
  logic [SHW-1:0]    shamt;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign wb_fire  = out_valid && out_ready && out_q.wb;

  regblock_rf #(.DWIDTH(DWIDTH), .RWIDTH(RWIDTH), .ZERO_REG(ZERO_REG)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_a    (rs),
    .ra_b    (rt),
    .rd_a    (op_a),
    .rd_b    (rt_val),
    .wb_en   (wb_fire),
    .wb_addr (out_q.rd),
    .wb_data (out_q.res),
    .we      (we),
    .wa      (wa),
    .wd      (wd)
  );

  assign imm_ext = imm_sext ? {{(DWIDTH-IWIDTH){imm_in[IWIDTH-1]}}, imm_in}
                            : {{(DWIDTH-IWIDTH){1'b0}}, imm_in};
  assign op_b    = muxsel1 ? imm_ext : rt_val;
  assign shamt   = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op_e'(ALUopsel))
      ALU_ADD: begin
        alu_res = op_a + op_b;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
      ALU_SLT:   alu_res[0] = $signed(op_a) < $signed(op_b);
      ALU_SLTU:  alu_res[0] = op_a < op_b;
      ALU_PASSA: alu_res = op_a;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    nxt      = '0;
    nxt.res  = alu_res;
    nxt.opb  = rt_val;
    nxt.rd   = rd;
    nxt.zero = (alu_res == '0);
    nxt.ovf  = alu_ovf;
    nxt.wb   = wb_en;
  end

  // Stage only reloads on accept, so a stalled result holds every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_q     <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ALUresult = out_q.res;
  assign opBwd     = out_q.opb;
  assign out_rd    = out_q.rd;
  assign zero      = out_q.zero;
  assign ovf       = out_q.ovf;

endmodule

// File: tb/tb_regblock_pipe.sv
module tb_regblock_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  rs, rt, rd, wa, out_rd;
  logic [14:0] imm_in;
  logic        imm_sext, muxsel1, wb_en, we;
  logic [3:0]  ALUopsel;
  logic [31:0] wd, ALUresult, opBwd;
  logic        out_valid, out_ready, zero, ovf;

  always #5 clk = ~clk;

  regblock_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .imm_in(imm_in), .imm_sext(imm_sext),
    .muxsel1(muxsel1), .wb_en(wb_en), .ALUopsel(ALUopsel),
    .we(we), .wa(wa), .wd(wd), .out_valid(out_valid), .out_ready(out_ready),
    .ALUresult(ALUresult), .opBwd(opBwd), .out_rd(out_rd), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] opb;
    logic [5:0]  rd;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every retire pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_retire: got result %h expected no result", ALUresult);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, ".res"},  ALUresult, e.res);
        chk({e.name, ".opb"},  opBwd, e.opb);
        chk({e.name, ".rd"},   32'(out_rd), 32'(e.rd));
        chk({e.name, ".zero"}, 32'(zero), 32'(e.res == 32'h0));
        chk({e.name, ".ovf"},  32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input string nm, input logic [3:0] op,
                       input logic [5:0] rs_, input logic [5:0] rt_, input logic [5:0] rd_,
                       input logic [14:0] imm, input logic sext, input logic msel, input logic wbe,
                       input logic xwe, input logic [5:0] xwa, input logic [31:0] xwd,
                       input logic [31:0] e_res, input logic [31:0] e_opb, input logic e_ovf);
    exp_t e;
    int   n;
    ALUopsel = op; rs = rs_; rt = rt_; rd = rd_; imm_in = imm; imm_sext = sext;
    muxsel1 = msel; wb_en = wbe; we = xwe; wa = xwa; wd = xwd; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        n_chk++; n_fail++;
        $display("FAIL %s.accept_timeout: got in_ready 0 expected 1", nm);
        break;
      end
    end
    e.res = e_res; e.opb = e_opb; e.rd = rd_; e.ovf = e_ovf; e.name = nm;
    q.push_back(e);
    @(posedge clk); #1;
    chk({nm, ".latency"}, 32'(out_valid), 32'd1);
    in_valid = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; we = 1'b0; wa = '0; wd = '0;
    rs = '0; rt = '0; rd = '0; imm_in = '0; imm_sext = 1'b0; muxsel1 = 1'b0;
    wb_en = 1'b0; ALUopsel = '0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.ALUresult", ALUresult, 32'h0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // external writes then add
    wr(6'd7, 32'h0000AAAA);
    wr(6'd56, 32'hBBBB0000);
    wr(6'd10, 32'h7FFFFFFF);
    issue("add_rr", 4'b0000, 7, 56, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBAAAA, 32'hBBBB0000, 0);
    issue("sub_imm", 4'b0011, 7, 63, 0, 15'h0AA9, 0, 1, 0, 0, 0, 0, 32'h0000A001, 32'h0, 0);
    issue("sext1", 4'b0000, 0, 0, 0, 15'h7FFF, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 0);
    issue("sext0", 4'b0000, 0, 0, 0, 15'h7FFF, 0, 1, 0, 0, 0, 0, 32'h00007FFF, 32'h0, 0);

    // misc ALU ops
    issue("sra", 4'b0111, 56, 0, 0, 15'd4, 0, 1, 0, 0, 0, 0, 32'hFBBBB000, 32'h0, 0);
    issue("srl", 4'b0110, 56, 0, 0, 15'd4, 0, 1, 0, 0, 0, 0, 32'h0BBBB000, 32'h0, 0);
    issue("sll", 4'b0101, 7, 0, 0, 15'd4, 0, 1, 0, 0, 0, 0, 32'h000AAAA0, 32'h0, 0);
    issue("slt", 4'b1000, 56, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h0000AAAA, 0);
    issue("sltu", 4'b1001, 56, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000AAAA, 0);
    issue("xor", 4'b0100, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000AAAA, 0);
    issue("and", 4'b0001, 7, 56, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hBBBB0000, 0);
    issue("or", 4'b0010, 7, 56, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBAAAA, 32'hBBBB0000, 0);
    issue("sub_ovf", 4'b0011, 10, 56, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC444FFFF, 32'hBBBB0000, 1);
    issue("bad_op", 4'b1010, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000AAAA, 0);
    issue("add_ovf", 4'b0000, 10, 0, 0, 15'd1, 0, 1, 0, 0, 0, 0, 32'h80000000, 32'h0, 1);

    // stall: let last result retire, then hold out_ready low
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("passa_stall", 4'b1111, 7, 56, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0000AAAA, 32'hBBBB0000, 0);
    ALUopsel = 4'b0000; rs = 7; rt = 56; rd = 9; muxsel1 = 0; wb_en = 1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.ALUresult", ALUresult, 32'h0000AAAA);
      chk("stall.out_rd", 32'(out_rd), 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    // dependent chain with colliding external write to reg 9
    issue("wb_r9", 4'b0000, 7, 56, 9, 0, 0, 0, 1, 0, 0, 0, 32'hBBBBAAAA, 32'hBBBB0000, 0);
    issue("bypass_r9", 4'b0000, 9, 9, 0, 0, 0, 0, 0, 1, 9, 32'h11111111, 32'h77775554, 32'hBBBBAAAA, 1);
    issue("read_r9", 4'b1111, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBAAAA, 32'hBBBBAAAA, 0);

    // register 0
    wr(6'd0, 32'h00001234);
    issue("r0_read", 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    issue("r0_wb", 4'b0000, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0000AAAA, 32'h0, 0);
    issue("r0_bypass", 4'b1111, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00001234, 32'h0, 32'h0, 0);

    // reset with a pending write-back result
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("dropped", 4'b1111, 10, 0, 7, 0, 0, 0, 1, 0, 0, 0, 32'h7FFFFFFF, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.ALUresult", ALUresult, 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    issue("post_rst_r7", 4'b1111, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    issue("post_rst_r10", 4'b1111, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("drain.queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
